// File: rtl/input_pre_data_module.sv
// Byte-serial to wide-parallel staging for the PE array: collects NUM_WORDS samples
// into a fill buffer and hands it to a held output word on a ping-pong switch.
module input_pre_data_module #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_WORDS = 34,
    parameter int unsigned OUT_W     = 272
) (
    input  logic              dout_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] i_data_din,
    input  logic              i_data_din_vld,
    input  logic              i_switch_pingpong,
    output logic              PEclk,
    output logic [0:OUT_W-1]  prallel_data
);

    localparam int unsigned PTR_W = $clog2(NUM_WORDS + 1);

    logic [0:OUT_W-1] fill_q, fill_d, fill_wr;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             full_q, full_d;
    logic [0:OUT_W-1] data_q, data_d;
    logic             peclk_q, peclk_d;

    // Write lands first so a same-cycle sample rides along with the switch.
    always_comb begin
        fill_wr  = fill_q;
        fill_d   = fill_q;
        wr_ptr_d = wr_ptr_q;
        full_d   = full_q;
        data_d   = data_q;
        peclk_d  = 1'b0;

        if (en && i_data_din_vld && !full_q) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                if (wr_ptr_q == PTR_W'(i)) begin
                    fill_wr[i*DATA_W +: DATA_W] = i_data_din;
                end
            end
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            full_d   = (wr_ptr_q == PTR_W'(NUM_WORDS - 1));
        end

        if (en && i_switch_pingpong) begin
            data_d   = fill_wr;
            fill_d   = '0;
            wr_ptr_d = '0;
            full_d   = 1'b0;
            peclk_d  = 1'b1;
        end else begin
            fill_d   = fill_wr;
        end
    end

    // rst_n is active-high and synchronous.
    always_ff @(posedge dout_clk) begin
        if (rst_n) begin
            fill_q   <= '0;
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
            data_q   <= '0;
            peclk_q  <= 1'b0;
        end else begin
            fill_q   <= fill_d;
            wr_ptr_q <= wr_ptr_d;
            full_q   <= full_d;
            data_q   <= data_d;
            peclk_q  <= peclk_d;
        end
    end

    assign PEclk        = peclk_q;
    assign prallel_data = data_q;

endmodule

// File: tb/tb_input_pre_data_module.sv
// Directed bench for input_pre_data_module: byte-array model feeds a scoreboard
// queue per edge; DUT outputs are popped and compared 1 time unit after each edge.
module tb_input_pre_data_module;

    localparam int unsigned NW = 34;
    localparam int unsigned OW = 272;

    logic          dout_clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [7:0]    i_data_din;
    logic          i_data_din_vld;
    logic          i_switch_pingpong;
    logic          PEclk;
    logic [0:OW-1] prallel_data;

    input_pre_data_module dut (
        .dout_clk          (dout_clk),
        .rst_n             (rst_n),
        .en                (en),
        .i_data_din        (i_data_din),
        .i_data_din_vld    (i_data_din_vld),
        .i_switch_pingpong (i_switch_pingpong),
        .PEclk             (PEclk),
        .prallel_data      (prallel_data)
    );

    always #5 dout_clk = ~dout_clk;

    typedef struct {
        logic          pe;
        logic [0:OW-1] data;
    } exp_t;

    exp_t          sb[$];
    logic [7:0]    mdl_bytes[NW];
    int            mdl_cnt;
    logic [0:OW-1] mdl_out;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int k = 0; k < NW; k++) mdl_bytes[k] = 8'h00;
        mdl_cnt = 0;
    endtask

    // Drive one edge worth of inputs, predict, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic v, input logic s,
                        input logic [7:0] d, input string tag);
        exp_t x;
        exp_t got;
        rst_n = r; en = e; i_data_din_vld = v; i_switch_pingpong = s; i_data_din = d;
        x.pe = 1'b0;
        if (r) begin
            mdl_clear();
            mdl_out = '0;
        end else if (e) begin
            if (v && mdl_cnt < NW) begin
                mdl_bytes[mdl_cnt] = d;
                mdl_cnt++;
            end
            if (s) begin
                for (int k = 0; k < NW; k++)
                    for (int b = 0; b < 8; b++)
                        mdl_out[8*k + b] = mdl_bytes[k][7-b];
                mdl_clear();
                x.pe = 1'b1;
            end
        end
        x.data = mdl_out;
        sb.push_back(x);
        @(posedge dout_clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".peclk"}, OW'(PEclk), OW'(got.pe));
        chk({tag, ".data"}, prallel_data, got.data);
    endtask

    initial begin
        mdl_clear();
        mdl_out = '0;

        // 1: reset with random inputs, then idle
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), "rst");
        chk("rst_zero", prallel_data, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "idle");

        // 2: full fill then switch
        for (int i = 1; i <= 34; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(i), "fill");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sw_full");
        chk("full_b0", OW'(prallel_data[0:7]), OW'(8'h01));
        chk("full_b1", OW'(prallel_data[8:15]), OW'(8'h02));
        chk("full_b33", OW'(prallel_data[264:271]), OW'(8'h22));
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "hold");

        // 3: overflow drops extra bytes
        for (int i = 1; i <= 40; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(i), "ovf");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sw_ovf");
        chk("ovf_b33", OW'(prallel_data[264:271]), OW'(8'h22));

        // 4: partial fill with sample on the switch cycle
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, "part");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'hBB, "part");
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'hCC, "sw_part");
        chk("part_head", OW'(prallel_data[0:23]), OW'(24'hAABBCC));
        chk("part_tail", OW'(prallel_data[24:271]), '0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, "part2");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sw_part2");
        chk("part2_word", prallel_data, {8'h11, 264'b0});

        // back-to-back switches, second carries a same-cycle sample
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "b2b_1");
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, "b2b_2");
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "b2b_end");

        // 5: enable freeze
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h10, "frz_pre");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h20, "frz_pre");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'h99, "frz");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h30, "frz_post");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sw_frz");
        chk("frz_word", prallel_data, {24'h102030, 248'b0});

        // 6: reset mid-fill
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'(8'hE0 + i), "mid");
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hEE, "mid_rst");
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55, "post_rst");
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, "sw_rst");
        chk("rst_word", prallel_data, {8'h55, 264'b0});
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_pre_data_module.md
Name: input_pre_data_module

Overview:
- Byte-serial to wide-parallel input staging block in front of the PE array.
- Collects 8-bit samples into a 34-byte (272-bit) fill buffer.
- On a ping-pong switch command, transfers the filled buffer to a held output register and signals the PE array with a one-cycle PEclk strobe.
- Fully synchronous, single clock domain.

Parameters:
DATA_W, 8, width of one input sample
NUM_WORDS, 34, samples per parallel word
OUT_W, 272, output width; must equal DATA_W*NUM_WORDS

Ports:
- dout_clk  input  1  sole clock; all logic on rising edge. i_data_din is synchronous to it.
- rst_n  input  1  synchronous reset, ACTIVE-HIGH despite the name. 1 = reset on the next rising edge.
- en  input  1  global enable; 0 freezes all state.
- i_data_din  input  DATA_W  input sample.
- i_data_din_vld  input  1  sample valid qualifier.
- i_switch_pingpong  input  1  single-cycle command to hand the fill buffer to the output.
- PEclk  output  1  registered one-cycle strobe marking new prallel_data.
- prallel_data  output  [0:OUT_W-1]  held parallel word. Ascending index; bit 0 is the MSB of sample 0.

Behaviour:
- Single clock: dout_clk. There is no separate din_clk port; upstream provides data on dout_clk.

Reset (rst_n=1 at an edge; overrides everything else):
- fill buffer = 0, wr_ptr = 0, full = 0
- prallel_data = 0, PEclk = 0

en=0:
- No write, no switch, no pointer change.
- prallel_data holds.
- PEclk = 0 on the next edge.

Write (en=1, i_data_din_vld=1, full=0):
- Sample is stored at slot wr_ptr, i.e. fill[8*wr_ptr : 8*wr_ptr+7], MSB at the lower index.
- wr_ptr increments.
- When wr_ptr reaches NUM_WORDS (34), full is set.

Overflow (vld=1, full=1):
- Sample is dropped silently.
- No state change.

Switch (en=1, i_switch_pingpong=1):
- prallel_data <= fill buffer contents, including any sample written in the same cycle.
- Fill buffer is cleared to 0; wr_ptr = 0; full = 0.
- PEclk = 1 for exactly that next cycle, aligned with the new prallel_data.
- A partial buffer is transferred as-is; unwritten slots are 0.

Simultaneous vld + switch:
- The sample is first placed at the current wr_ptr (if not full), then the switch happens.
- The sample appears in the transferred word, not in the new fill buffer.

Other rules:
- Back-to-back switches: the second transfers an all-zero word (plus any same-cycle sample); PEclk stays high for both cycles.
- PEclk = 0 in every cycle that does not follow a switch.
- Latency: sample to prallel_data = 1 cycle after the switch edge. Switch edge to PEclk high = 1 cycle.
- prallel_data changes only on a switch or reset.
- Reset mid-fill discards the partial buffer and zeroes the output.
- Unknown-free: all state has a reset value.

Test Plan:
1. Reset: rst_n=1 for 2 cycles with random inputs -> prallel_data=0, PEclk=0. Release, no vld -> outputs stay 0.
2. Full fill: en=1; feed 34 valid bytes 0x01..0x22, then switch=1 for one cycle.
   - Next cycle: PEclk=1, prallel_data[0:7]=0x01, [8:15]=0x02, [264:271]=0x22.
   - Following cycle: PEclk=0, data holds.
3. Overflow: feed 40 bytes 0x01..0x28, then switch -> word holds 0x01..0x22; bytes 0x23..0x28 are absent.
4. Partial + simultaneous: feed 0xAA, 0xBB, then 0xCC with switch=1 in the same cycle.
   - Next: [0:23]=0xAABBCC, [24:271]=0.
   - Then feed 0x11 and switch -> [0:7]=0x11, rest 0.
5. Enable freeze: en=0 while vld=1 and switch=1 for 5 cycles -> no byte captured, prallel_data unchanged, PEclk=0.
   - en=1, then switch -> word reflects only bytes written while en=1.
6. Reset mid-operation: write 10 bytes, assert rst_n=1 for one cycle, write 0x55, switch -> [0:7]=0x55, rest 0.
